// File: rtl/fetch_unit_pkg.sv
// Shared widths, constants, state encoding and bus payloads for the fetch stage.
package fetch_unit_pkg;

    localparam int unsigned StallBus       = 6;
    localparam int unsigned BR_WD          = 33;
    localparam int unsigned FETCH_TO_ID_WD = 65;
    localparam int unsigned XLEN           = 32;

    localparam logic [XLEN-1:0] FETCH_RESET_PC = 32'hbfbf_fffc;
    localparam logic [XLEN-1:0] FETCH_BOOT_PC  = FETCH_RESET_PC + 32'd4;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic            br_e;
        logic [XLEN-1:0] br_addr;
    } br_bus_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_to_id_t;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Free-running fetch/stall event counters; wrap at 2^32, cleared by rst.
module fetch_perf_cnt
    import fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_inc_i,
    input  logic            stall_inc_i,
    output logic [XLEN-1:0] fetch_cnt_o,
    output logic [XLEN-1:0] stall_cnt_o
);

    logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;

    // Next counter values; 32-bit add wraps naturally
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (fetch_inc_i) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (stall_inc_i) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM and
// presents {valid, pc, inst} to decode, holding the instruction in a skid
// register while stalled. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [StallBus-1:0]       stall,
    input  logic [BR_WD-1:0]          br_bus,
    output logic                      inst_sram_en,
    output logic [3:0]                inst_sram_wen,
    output logic [XLEN-1:0]           inst_sram_addr,
    output logic [XLEN-1:0]           inst_sram_wdata,
    input  logic [XLEN-1:0]           inst_sram_rdata,
    output logic [FETCH_TO_ID_WD-1:0] fetch_to_id_bus,
    output logic [XLEN-1:0]           fetch_cnt,
    output logic [XLEN-1:0]           stall_cnt
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] hold_inst_q, hold_inst_d;

    br_bus_t         br;
    fetch_to_id_t    bus_c;
    logic            en_c;
    logic [XLEN-1:0] addr_c;
    logic [XLEN-1:0] next_pc_c;
    logic            fetch_inc_c;
    logic            stall_inc_c;
    logic            stop;

    // stall[1] implies stall[0], so only the PC-hold bit matters here
    logic            unused_stall;
    assign unused_stall = ^stall[StallBus-1:1];

    assign br   = br_bus;
    assign stop = stall[0];

    // State, PC and skid registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH_IDLE;
            pc_q        <= FETCH_RESET_PC;
            hold_inst_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_inst_q <= hold_inst_d;
        end
    end

    // Next-state, next-PC and fetch/bundle outputs
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_inst_d = hold_inst_q;
        en_c        = 1'b0;
        addr_c      = pc_q;
        bus_c       = '0;
        fetch_inc_c = 1'b0;
        stall_inc_c = 1'b0;
        next_pc_c   = br.br_e ? br.br_addr : pc_q + 32'd4;

        case (state_q)
            FETCH_IDLE: begin
                // Boot fetch ignores both branch and stall
                next_pc_c = FETCH_BOOT_PC;
                en_c      = 1'b1;
                addr_c    = next_pc_c;
                pc_d      = next_pc_c;
                state_d   = FETCH_RUN;
            end
            FETCH_RUN: begin
                bus_c = '{valid: 1'b1, pc: pc_q, inst: inst_sram_rdata};
                if (stop == NoStop) begin
                    en_c        = 1'b1;
                    addr_c      = next_pc_c;
                    pc_d        = next_pc_c;
                    fetch_inc_c = 1'b1;
                end else begin
                    // Capture the SRAM word now; the SRAM output is not held for us
                    hold_inst_d = inst_sram_rdata;
                    stall_inc_c = 1'b1;
                    state_d     = FETCH_HOLD;
                end
            end
            FETCH_HOLD: begin
                bus_c = '{valid: 1'b1, pc: pc_q, inst: hold_inst_q};
                if (stop == NoStop) begin
                    en_c    = 1'b1;
                    addr_c  = next_pc_c;
                    pc_d    = next_pc_c;
                    state_d = FETCH_RUN;
                end else begin
                    stall_inc_c = 1'b1;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    // All outputs forced to zero while reset is asserted
    assign inst_sram_en    = rst ? 1'b0 : en_c;
    assign inst_sram_addr  = rst ? '0 : addr_c;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = '0;
    assign fetch_to_id_bus = rst ? '0 : bus_c;

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] fetch_cnt_w;
    logic [XLEN-1:0] stall_cnt_w;

    fetch_perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .fetch_inc_i (fetch_inc_c),
        .stall_inc_i (stall_inc_c),
        .fetch_cnt_o (fetch_cnt_w),
        .stall_cnt_o (stall_cnt_w)
    );

    assign fetch_cnt = rst ? '0 : fetch_cnt_w;
    assign stall_cnt = rst ? '0 : stall_cnt_w;
`else
    logic unused_perf;
    assign unused_perf = fetch_inc_c ^ stall_inc_c;
    assign fetch_cnt   = '0;
    assign stall_cnt   = '0;
`endif

endmodule
